// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load data extraction/extension and register-file
// write-port drive, with stall/flush handling and one-cycle misalign flag.
// Optional: define UNALIGNED_LOAD_EN to enable LWL/LWR merging (codes 6/7);
// without it those codes behave as LW and mem_rt_old is ignored.
module mem_wb_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        stall,
   input  logic              flush,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_waddr,
   input  logic [DATA_W-1:0] mem_result,
   input  logic [2:0]        mem_ld_type,
   input  logic [1:0]        mem_addr_lo,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [DATA_W-1:0] mem_rt_old,
   output logic              wb_we,
   output logic [ADDR_W-1:0] wb_waddr,
   output logic [DATA_W-1:0] wb_wdata,
   output logic              wb_misalign
);

   typedef enum logic [2:0] {
      LD_NONE = 3'd0,
      LD_B    = 3'd1,
      LD_BU   = 3'd2,
      LD_H    = 3'd3,
      LD_HU   = 3'd4,
      LD_W    = 3'd5,
      LD_WL   = 3'd6,
      LD_WR   = 3'd7
   } ld_type_e;

   ld_type_e          ld;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [DATA_W-1:0] ld_val;
   logic              ld_mis;

   assign ld = ld_type_e'(mem_ld_type);

   // Stall bits for earlier stages have no meaning here.
   logic unused_stall;
   assign unused_stall = ^stall[3:0];

`ifndef UNALIGNED_LOAD_EN
   logic unused_rt_old;
   assign unused_rt_old = ^mem_rt_old;
`endif

   // Select the byte/halfword lane and build the value to be written back.
   always_comb begin
      byte_sel = '0;
      half_sel = mem_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      ld_val   = mem_result;
      ld_mis   = 1'b0;
      case (mem_addr_lo)
         2'd0: byte_sel = mem_rdata[7:0];
         2'd1: byte_sel = mem_rdata[15:8];
         2'd2: byte_sel = mem_rdata[23:16];
         2'd3: byte_sel = mem_rdata[31:24];
         default: byte_sel = '0;
      endcase
      case (ld)
         LD_NONE: ld_val = mem_result;
         LD_B:    ld_val = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
         LD_BU:   ld_val = {{(DATA_W-8){1'b0}}, byte_sel};
         LD_H: begin
            ld_val = {{(DATA_W-16){half_sel[15]}}, half_sel};
            ld_mis = mem_addr_lo[0];
         end
         LD_HU: begin
            ld_val = {{(DATA_W-16){1'b0}}, half_sel};
            ld_mis = mem_addr_lo[0];
         end
         LD_W: begin
            ld_val = mem_rdata;
            ld_mis = (mem_addr_lo != 2'b00);
         end
`ifdef UNALIGNED_LOAD_EN
         LD_WL: begin
            case (mem_addr_lo)
               2'd0:    ld_val = {mem_rdata[7:0],  mem_rt_old[23:0]};
               2'd1:    ld_val = {mem_rdata[15:0], mem_rt_old[15:0]};
               2'd2:    ld_val = {mem_rdata[23:0], mem_rt_old[7:0]};
               default: ld_val = mem_rdata;
            endcase
         end
         LD_WR: begin
            case (mem_addr_lo)
               2'd0:    ld_val = mem_rdata;
               2'd1:    ld_val = {mem_rt_old[31:24], mem_rdata[31:8]};
               2'd2:    ld_val = {mem_rt_old[31:16], mem_rdata[31:16]};
               default: ld_val = {mem_rt_old[31:8],  mem_rdata[31:24]};
            endcase
         end
`else
         LD_WL:   ld_val = mem_rdata;
         LD_WR:   ld_val = mem_rdata;
`endif
         default: ld_val = mem_result;
      endcase
   end

   // Pipeline register: reset > flush > bubble on MEM-only stall > hold > capture.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wb_we       <= 1'b0;
         wb_waddr    <= '0;
         wb_wdata    <= '0;
         wb_misalign <= 1'b0;
      end else if (flush || (stall[4] && !stall[5])) begin
         wb_we       <= 1'b0;
         wb_waddr    <= '0;
         wb_wdata    <= '0;
         wb_misalign <= 1'b0;
      end else if (!stall[4]) begin
         wb_we       <= mem_we && (mem_waddr != '0) && !ld_mis;
         wb_waddr    <= mem_waddr;
         wb_wdata    <= ld_mis ? '0 : ld_val;
         wb_misalign <= ld_mis;
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed steps followed by random
// traffic, compared against an arithmetic reference model.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic        mem_we;
   logic [4:0]  mem_waddr;
   logic [31:0] mem_result;
   logic [2:0]  mem_ld_type;
   logic [1:0]  mem_addr_lo;
   logic [31:0] mem_rdata;
   logic [31:0] mem_rt_old;
   logic        wb_we;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic        wb_misalign;

   int unsigned n_vec  = 0;
   int unsigned n_fail = 0;

   // reference model state
   logic        e_we;
   logic [4:0]  e_waddr;
   logic [31:0] e_wdata;
   logic        e_mis;

   mem_wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_result(mem_result),
      .mem_ld_type(mem_ld_type), .mem_addr_lo(mem_addr_lo),
      .mem_rdata(mem_rdata), .mem_rt_old(mem_rt_old),
      .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .wb_misalign(wb_misalign)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] load_value(output logic mis);
      longint unsigned sh, b, h, mask;
      logic [31:0] v;
      sh  = 64'(mem_addr_lo) * 8;
      mis = 1'b0;
      b   = (64'(mem_rdata) >> sh) % 256;
      h   = (64'(mem_rdata) >> sh) % 65536;
      case (mem_ld_type)
         3'd1: v = (b >= 128) ? 32'(b + 64'hFFFFFF00) : 32'(b);
         3'd2: v = 32'(b);
         3'd3: begin mis = (mem_addr_lo % 2) != 0; v = (h >= 32768) ? 32'(h + 64'hFFFF0000) : 32'(h); end
         3'd4: begin mis = (mem_addr_lo % 2) != 0; v = 32'(h); end
         3'd5: begin mis = (mem_addr_lo != 0); v = mem_rdata; end
`ifdef UNALIGNED_LOAD_EN
         3'd6: begin
            mask = (64'd1 << (8 * (3 - 64'(mem_addr_lo)))) - 1;
            v = 32'((64'(mem_rdata) << (8 * (3 - 64'(mem_addr_lo)))) | (64'(mem_rt_old) & mask));
         end
         3'd7: begin
            mask = 64'hFFFFFFFF >> sh;
            v = 32'((64'(mem_rdata) >> sh) | (64'(mem_rt_old) & ~mask & 64'hFFFFFFFF));
         end
`endif
         3'd0: v = mem_result;
         default: v = mem_rdata;
      endcase
      if (mis) v = 32'd0;
      return v;
   endfunction

   // Advance the model using the inputs present before the coming edge.
   task automatic model_next();
      logic        mis;
      logic [31:0] v;
      if (!rst || flush || (stall[4] && !stall[5])) begin
         e_we = 0; e_waddr = 0; e_wdata = 0; e_mis = 0;
      end else if (!stall[4]) begin
         v       = load_value(mis);
         e_we    = mem_we && (mem_waddr != 0) && !mis;
         e_waddr = mem_waddr;
         e_wdata = v;
         e_mis   = mis;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      model_next();
      @(posedge clk);
      #1;
      check("we",   32'(wb_we),       32'(e_we));
      check("addr", 32'(wb_waddr),    32'(e_waddr));
      check("data", wb_wdata,         e_wdata);
      check("mis",  32'(wb_misalign), 32'(e_mis));
   endtask

   task automatic drive(input logic we, input logic [4:0] a, input logic [31:0] r,
                        input logic [2:0] ld, input logic [1:0] lo);
      mem_we = we; mem_waddr = a; mem_result = r; mem_ld_type = ld; mem_addr_lo = lo;
   endtask

   initial begin
      rst = 0; stall = '0; flush = 0;
      drive(1, 5'd3, 32'h1234, 3'd0, 2'd0);
      mem_rdata = '0; mem_rt_old = '0;
      e_we = 0; e_waddr = 0; e_wdata = 0; e_mis = 0;

      // reset holds outputs at zero
      step(); step();
      check("rst_we", 32'(wb_we), 32'd0);
      check("rst_data", wb_wdata, 32'd0);
      rst = 1;
      step();
      check("post_rst_we", 32'(wb_we), 32'd1);
      check("post_rst_data", wb_wdata, 32'h00001234);

      // byte/half extraction
      mem_rdata = 32'h80FF7F01;
      drive(1, 5'd7, 32'h0, 3'd1, 2'd3); step(); check("lb3",  wb_wdata, 32'hFFFFFF80);
      drive(1, 5'd7, 32'h0, 3'd2, 2'd1); step(); check("lbu1", wb_wdata, 32'h0000007F);
      drive(1, 5'd7, 32'h0, 3'd3, 2'd2); step(); check("lh2",  wb_wdata, 32'hFFFF80FF);
      drive(1, 5'd7, 32'h0, 3'd4, 2'd0); step(); check("lhu0", wb_wdata, 32'h00007F01);

      // misaligned word, then $zero destination
      drive(1, 5'd8, 32'h0, 3'd5, 2'd2); step();
      check("lw_mis_flag", 32'(wb_misalign), 32'd1);
      check("lw_mis_we",   32'(wb_we),       32'd0);
      drive(1, 5'd0, 32'd5, 3'd0, 2'd0); step();
      check("zero_we",   32'(wb_we),       32'd0);
      check("zero_data", wb_wdata,         32'd5);
      check("zero_mis",  32'(wb_misalign), 32'd0);

      // hold, bubble, flush, resume
      drive(1, 5'd9, 32'hDEAD, 3'd0, 2'd0);
      stall = 6'b110000;
      step(); step(); step();
      check("hold_data", wb_wdata, 32'd5);
      stall = 6'b010000; step(); check("bubble_we", 32'(wb_we), 32'd0);
      stall = 6'b000000; flush = 1; step(); check("flush_data", wb_wdata, 32'd0);
      flush = 0; step();
      check("resume_we", 32'(wb_we), 32'd1);
      check("resume_data", wb_wdata, 32'hDEAD);

      // back-to-back writes
      for (int i = 1; i <= 4; i++) begin
         drive(1, 5'(i), 32'(i), 3'd0, 2'd0);
         step();
         check("b2b_addr", 32'(wb_waddr), 32'(i));
      end

`ifdef UNALIGNED_LOAD_EN
      mem_rt_old = 32'hAABBCCDD; mem_rdata = 32'h11223344;
      drive(1, 5'd10, 32'h0, 3'd6, 2'd1); step(); check("lwl1", wb_wdata, 32'h3344CCDD);
      drive(1, 5'd10, 32'h0, 3'd7, 2'd2); step(); check("lwr2", wb_wdata, 32'hAABB1122);
`endif

      // reset during a full stall leaves a bubble
      drive(1, 5'd11, 32'h77, 3'd0, 2'd0);
      stall = 6'b110000; rst = 0; step();
      rst = 1; step();
      check("rst_stall_we", 32'(wb_we), 32'd0);
      stall = '0;

      // random traffic
      for (int n = 0; n < 400; n++) begin
         rst         = ($urandom_range(0, 39) != 0);
         flush       = ($urandom_range(0, 19) == 0);
         stall       = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
         mem_ld_type = 3'($urandom);
         mem_we      = (mem_ld_type != 0) ? 1'b1 : 1'($urandom);
         mem_waddr   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         mem_result  = $urandom;
         mem_addr_lo = 2'($urandom);
         mem_rdata   = $urandom;
         mem_rt_old  = $urandom;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
